// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch-path constants and the fetch-entry type
package instr_fetch_unit_pkg;

  localparam int CPU_ADDR_W  = 32;
  localparam int CPU_INSTR_W = 32;
  localparam int PC_STEP     = 4;
  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0]  pc;
    logic [CPU_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [CPU_ADDR_W-1:0] align_pc(input logic [CPU_ADDR_W-1:0] a);
    return {a[CPU_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - control, instruction-memory and decode signals of the fetch unit
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              start;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    input  start, redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output start, redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// rtl/instr_fetch_unit_sync_fifo.sv - in-order prefetch queue with flush
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is left untouched by reset/flush; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential instruction prefetcher with credit-limited
// pipelined requests, prefetch queue and branch redirect
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_INSTR_W,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

  logic                     run;
  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        resp_pc;
  logic [CW-1:0]            outstanding;
  logic [CW-1:0]            drop_cnt;
  logic [CW-1:0]            q_count;
  logic                     q_empty;
  logic [ADDR_W+DATA_W-1:0] q_head;
  logic [CW:0]              credits_used;
  logic [ADDR_W-1:0]        target_pc;
  logic                     grant;
  logic                     push;
  logic                     pop;
  logic                     flush;

  assign target_pc    = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign credits_used = {1'b0, q_count} + {1'b0, outstanding};

  // Queued plus in-flight words never exceed DEPTH, so a returning word always has a slot.
  assign bus.mem_req  = run && !bus.redirect_valid && (credits_used < DEPTH_C);
  assign bus.mem_addr = fetch_pc;

  assign flush = bus.redirect_valid;
  assign grant = bus.mem_req && bus.mem_gnt;
  assign push  = bus.mem_rvalid && (drop_cnt == '0) && !flush;
  assign pop   = bus.instr_valid && bus.instr_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (bus.start) run <= 1'b1;
      outstanding <= outstanding + CW'(grant) - CW'(bus.mem_rvalid);
      if (flush) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        // Every response still in flight is stale, which already covers earlier drops.
        drop_cnt <= outstanding - CW'(bus.mem_rvalid);
      end else begin
        if (grant) fetch_pc <= fetch_pc + STEP;
        if (push)  resp_pc  <= resp_pc + STEP;
        if (bus.mem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata({resp_pc, bus.mem_rdata}),
    .rdata(q_head),
    .count(q_count),
    .empty(q_empty)
  );

  assign bus.instr_valid = !q_empty;
  assign bus.instr_pc    = q_empty ? '0 : q_head[ADDR_W+DATA_W-1:DATA_W];
  assign bus.instr       = q_empty ? '0 : q_head[DATA_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus5 ();

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000))
    dut (.clk(clk), .rst(rst), .bus(bus));
  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8))
    dut5 (.clk(clk), .rst(rst), .bus(bus5));

  int checks = 0;
  int errors = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t exp5_q[$];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory model for the main DUT: in-order, one response per cycle, optional hold.
  logic [31:0] pend[$];
  logic [31:0] ra;
  int          gnt_cnt;
  int          gnt_limit;
  bit          hold;
  int          inflight;
  assign bus.mem_gnt = (gnt_cnt < gnt_limit);

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      bus.mem_rvalid <= 1'b0;
      bus.mem_rdata  <= '0;
      gnt_cnt        <= 0;
      inflight       <= 0;
    end else begin
      inflight <= inflight + int'(bus.mem_req && bus.mem_gnt) - int'(bus.mem_rvalid);
      if (bus.mem_req && bus.mem_gnt) begin
        pend.push_back(bus.mem_addr);
        gnt_cnt <= gnt_cnt + 1;
      end
      if (!hold && pend.size() > 0) begin
        ra = pend.pop_front();
        bus.mem_rvalid <= 1'b1;
        bus.mem_rdata  <= rom(ra);
      end else begin
        bus.mem_rvalid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) assert (!(bus.mem_rvalid && inflight == 0)) else $error("rvalid with nothing in flight");
  end

  assign bus5.mem_gnt = 1'b1;
  always @(posedge clk) begin
    if (rst) begin
      bus5.mem_rvalid <= 1'b0;
      bus5.mem_rdata  <= '0;
    end else begin
      bus5.mem_rvalid <= bus5.mem_req && bus5.mem_gnt;
      bus5.mem_rdata  <= rom(bus5.mem_addr);
    end
  end

  // Monitors: each handshake seen here completes at the following rising edge.
  fetch_entry_t got;
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_instr actual_pc=%h required=none", bus.instr_pc);
      end else begin
        got = exp_q.pop_front();
        check("instr_pc", 64'(bus.instr_pc), 64'(got.pc));
        check("instr_data", 64'(bus.instr), 64'(got.instr));
      end
    end
  end

  fetch_entry_t got5;
  always @(negedge clk) begin
    if (!rst && bus5.instr_valid && bus5.instr_ready) begin
      if (exp5_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_instr5 actual_pc=%h required=none", bus5.instr_pc);
      end else begin
        got5 = exp5_q.pop_front();
        check("instr_pc5", 64'(bus5.instr_pc), 64'(got5.pc));
        check("instr_data5", 64'(bus5.instr), 64'(got5.instr));
      end
    end
  end

  task automatic expect_seq(input bit which, input logic [31:0] pc0, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = pc0 + 32'(4 * i);
      e.instr = rom(e.pc);
      if (which) exp5_q.push_back(e);
      else       exp_q.push_back(e);
    end
  endtask

  task automatic drain(input bit which, input int maxc);
    int n = 0;
    if (which) bus5.instr_ready = 1'b1;
    else       bus.instr_ready  = 1'b1;
    while (((which ? exp5_q.size() : exp_q.size()) > 0) && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.instr_ready  = 1'b0;
    bus5.instr_ready = 1'b0;
    check("drain_left", 64'(which ? exp5_q.size() : exp_q.size()), 64'd0);
    exp_q.delete();
    exp5_q.delete();
  endtask

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) bus5.start = 1'b1; else bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus5.start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.start = 0;  bus.redirect_valid = 0;  bus.redirect_pc = '0;  bus.instr_ready = 0;
    bus5.start = 0; bus5.redirect_valid = 0; bus5.redirect_pc = '0; bus5.instr_ready = 0;
    hold = 0; gnt_limit = 1000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_instr", 64'(bus.instr), 64'd0);
    check("rst_instr_pc", 64'(bus.instr_pc), 64'd0);
    check("rst_mem_addr5", 64'(bus5.mem_addr), 64'hFFFF_FFF8);
    rst = 1'b0;

    // 1: streaming with ready held high
    pulse_start(0);
    expect_seq(0, 32'h0, 8);
    drain(0, 60);
    do_reset();

    // 2: decode stalled, credit cap of 4
    pulse_start(0);
    repeat (12) @(negedge clk);
    check("stall_grants", 64'(gnt_cnt), 64'd4);
    check("stall_mem_req", 64'(bus.mem_req), 64'd0);
    check("stall_valid", 64'(bus.instr_valid), 64'd1);
    check("stall_head_pc", 64'(bus.instr_pc), 64'h0);
    expect_seq(0, 32'h0, 4);
    drain(0, 30);
    do_reset();

    // 3: redirect with two responses in flight
    gnt_limit = 2; hold = 1;
    pulse_start(0);
    repeat (5) @(negedge clk);
    check("wait_mem_req", 64'(bus.mem_req), 64'd1);
    check("wait_mem_addr", 64'(bus.mem_addr), 64'h8);
    check("wait_valid", 64'(bus.instr_valid), 64'd0);
    bus.redirect_valid = 1; bus.redirect_pc = 32'h100; gnt_limit = 1000;
    @(negedge clk);
    bus.redirect_valid = 0; hold = 0;
    check("redir_mem_addr", 64'(bus.mem_addr), 64'h100);
    expect_seq(0, 32'h100, 3);
    drain(0, 40);
    do_reset();

    // 4: misaligned redirect in the same cycle as a response
    gnt_limit = 1; hold = 1;
    pulse_start(0);
    repeat (4) @(negedge clk);
    hold = 0;
    waited = 0;
    while (!bus.mem_rvalid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("rvalid_seen", 64'(bus.mem_rvalid), 64'd1);
    bus.redirect_valid = 1; bus.redirect_pc = 32'h103; gnt_limit = 1000;
    @(negedge clk);
    check("redir4_mem_addr", 64'(bus.mem_addr), 64'h100);
    check("redir4_valid", 64'(bus.instr_valid), 64'd0);
    bus.redirect_valid = 0;
    expect_seq(0, 32'h100, 2);
    drain(0, 40);
    do_reset();

    // 6: reset with three queued entries
    gnt_limit = 3;
    pulse_start(0);
    repeat (8) @(negedge clk);
    check("full3_valid", 64'(bus.instr_valid), 64'd1);
    check("full3_mem_req", 64'(bus.mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(bus.instr_valid), 64'd0);
    check("midrst_mem_req", 64'(bus.mem_req), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_mem_req", 64'(bus.mem_req), 64'd0);
    check("idle_mem_addr", 64'(bus.mem_addr), 64'h0);

    // 5: wrap-around from a high reset PC
    pulse_start(1);
    expect_seq(1, 32'hFFFF_FFF8, 3);
    drain(1, 30);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
